// File: rtl/bldc_run_sequencer.sv
// bldc_run_sequencer: start/align/spin-up/run/brake/fault supervisor for a hall-sensed BLDC drive.
// Gates the commutator phase drive and reports stall, invalid-hall and reverse-rotation faults.
module bldc_run_sequencer #(
    parameter int counter_width = 32,
    parameter int align_cycles  = 540_000,
    parameter int spinup_edges  = 6,
    parameter int stall_cycles  = 5_400_000,
    parameter int brake_cycles  = 2_700_000
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] dir_req,
    input  logic       fault_clear,
    input  logic [2:0] hall_values,
    input  logic [1:0] detected_dir,
    input  logic [5:0] phase_enable_in,
    output logic [1:0] dir,
    output logic [5:0] phase_enable,
    output logic [2:0] state,
    output logic       running,
    output logic [1:0] fault_code
);
    typedef enum logic [2:0] {IDLE = 3'd0, ALIGN = 3'd1, SPINUP = 3'd2, RUN = 3'd3, BRAKE = 3'd4, FAULT = 3'd5} state_t;
    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam int cw = $clog2(spinup_edges + 1);
    localparam logic [counter_width-1:0] align_last = counter_width'(align_cycles - 1);
    localparam logic [counter_width-1:0] stall_last = counter_width'(stall_cycles - 1);
    localparam logic [counter_width-1:0] brake_last = counter_width'(brake_cycles - 1);
    localparam logic [cw-1:0] spin_last = cw'(spinup_edges - 1);

    state_t cur, nxt;
    logic [counter_width-1:0] timer, timer_nxt;
    logic [cw-1:0] cnt, cnt_nxt;
    logic [2:0] hall_q;
    logic armed;
    logic [1:0] dir_nxt, fault_nxt;
    logic hall_edge, hall_bad, active, reverse;

    // armed stays low for the first cycle after reset so the stale hall register cannot fake an edge
    assign hall_edge = armed && (hall_values != hall_q);
    assign hall_bad = (hall_values == 3'b000) || (hall_values == 3'b111);
    assign active = (cur == ALIGN) || (cur == SPINUP) || (cur == RUN);
    assign reverse = (detected_dir != DIR_NONE) && (detected_dir == {dir[0], dir[1]});
    assign state = cur;
    assign running = (cur == RUN);
    assign phase_enable = active ? phase_enable_in : (cur == BRAKE) ? 6'b000111 : 6'b000000;

    always_comb begin
        nxt = cur;
        dir_nxt = dir;
        fault_nxt = fault_code;
        cnt_nxt = cnt;
        case (cur)
            IDLE: if (start && !stop && dir_req != DIR_NONE) begin
                nxt = ALIGN;
                dir_nxt = dir_req;
            end
            ALIGN: nxt = (timer >= align_last) ? SPINUP : ALIGN;
            SPINUP: if (hall_edge) begin
                cnt_nxt = (detected_dir == dir) ? cnt + cw'(1) : '0;
                nxt = (detected_dir == dir && cnt == spin_last) ? RUN : SPINUP;
            end else if (timer >= stall_last) begin
                nxt = FAULT;
                fault_nxt = 2'd1;
            end
            RUN: if (hall_edge && reverse) begin
                nxt = FAULT;
                fault_nxt = 2'd3;
            end else if (!hall_edge && timer >= stall_last) begin
                nxt = FAULT;
                fault_nxt = 2'd1;
            end
            BRAKE: if (timer >= brake_last) begin
                nxt = IDLE;
                dir_nxt = DIR_NONE;
            end
            FAULT: if (fault_clear) begin
                nxt = IDLE;
                dir_nxt = DIR_NONE;
                fault_nxt = 2'd0;
            end
            default: begin
                nxt = IDLE;
                dir_nxt = DIR_NONE;
                fault_nxt = 2'd0;
            end
        endcase
        if (active && hall_edge && hall_bad) begin
            nxt = FAULT;
            fault_nxt = 2'd2;
        end
        if (active && stop) begin
            nxt = BRAKE;
            fault_nxt = fault_code;
        end
        cnt_nxt = (cur == SPINUP && nxt == SPINUP) ? cnt_nxt : '0;
        timer_nxt = (nxt != cur || (hall_edge && (cur == SPINUP || cur == RUN))) ? '0 :
                    (&timer) ? timer : timer + counter_width'(1);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cur <= IDLE;
            dir <= DIR_NONE;
            fault_code <= 2'd0;
            timer <= '0;
            cnt <= '0;
            hall_q <= 3'b000;
            armed <= 1'b0;
        end else begin
            cur <= nxt;
            dir <= dir_nxt;
            fault_code <= fault_nxt;
            timer <= timer_nxt;
            cnt <= cnt_nxt;
            hall_q <= hall_values;
            armed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bldc_run_sequencer.sv
// tb_bldc_run_sequencer: directed checks of the run sequencer with short timing parameters.
module tb_bldc_run_sequencer;
    logic pclk = 1'b0;
    logic preset_n = 1'b0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic fault_clear = 1'b0;
    logic [2:0] hall_values = 3'b101;
    logic [1:0] detected_dir = 2'd1;
    logic [5:0] phase_enable_in = 6'b100001;
    logic [1:0] dir;
    logic [5:0] phase_enable;
    logic [2:0] state;
    logic running;
    logic [1:0] fault_code;
    int tests = 0;
    int fails = 0;
    logic [2:0] seq [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    bldc_run_sequencer #(
        .counter_width(16), .align_cycles(10), .spinup_edges(6), .stall_cycles(50), .brake_cycles(20)
    ) dut (
        .pclk(pclk), .preset_n(preset_n), .start(start), .stop(stop), .dir_req(dir_req),
        .fault_clear(fault_clear), .hall_values(hall_values), .detected_dir(detected_dir),
        .phase_enable_in(phase_enable_in), .dir(dir), .phase_enable(phase_enable),
        .state(state), .running(running), .fault_code(fault_code)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic go_run(input int gap);
        hall_values = 3'b101;
        detected_dir = 2'd1;
        tick(1);
        start = 1'b1;
        dir_req = 2'd1;
        tick(1);
        start = 1'b0;
        tick(10);
        chk("go_spinup", 32'(state), 32'd2);
        for (int k = 0; k < 6; k++) begin
            hall_values = seq[k];
            tick(1);
            if (k < 5) tick(gap - 1);
        end
        chk("go_run", 32'(state), 32'd3);
    endtask

    initial begin
        tick(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_phase", 32'(phase_enable), 32'd0);
        chk("rst_misc", {28'd0, dir, running, fault_code[0]}, 32'd0);
        preset_n = 1'b1;
        tick(2);
        start = 1'b1;
        dir_req = 2'd1;
        tick(1);
        start = 1'b0;
        chk("align_enter", 32'(state), 32'd1);
        chk("align_dir", 32'(dir), 32'd1);
        chk("align_phase", 32'(phase_enable), 32'b100001);
        tick(9);
        chk("align_last", 32'(state), 32'd1);
        tick(1);
        chk("spinup_enter", 32'(state), 32'd2);
        for (int k = 0; k < 6; k++) begin
            hall_values = seq[k];
            if (k == 5) chk("spinup_before6", 32'(state), 32'd2);
            tick(1);
            if (k < 5) tick(19);
        end
        chk("run_enter", 32'(state), 32'd3);
        chk("run_running", 32'(running), 32'd1);
        tick(49);
        chk("stall_not_yet", 32'(state), 32'd3);
        tick(1);
        chk("stall_state", 32'(state), 32'd5);
        chk("stall_code", 32'(fault_code), 32'd1);
        chk("stall_phase", 32'(phase_enable), 32'd0);
        chk("stall_running", 32'(running), 32'd0);
        start = 1'b1;
        tick(3);
        chk("fault_start_ign", 32'(state), 32'd5);
        start = 1'b0;
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        chk("clear_state", 32'(state), 32'd0);
        chk("clear_code", 32'(fault_code), 32'd0);
        chk("clear_dir", 32'(dir), 32'd0);
        start = 1'b1;
        dir_req = 2'd0;
        tick(3);
        chk("idle_none_ign", 32'(state), 32'd0);
        start = 1'b0;
        start = 1'b1;
        dir_req = 2'd1;
        tick(1);
        start = 1'b0;
        tick(10);
        chk("hall_spinup", 32'(state), 32'd2);
        hall_values = 3'b100;
        tick(5);
        hall_values = 3'b111;
        tick(1);
        chk("hall_bad_state", 32'(state), 32'd5);
        chk("hall_bad_code", 32'(fault_code), 32'd2);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        go_run(5);
        stop = 1'b1;
        detected_dir = 2'd2;
        hall_values = 3'b001;
        tick(1);
        stop = 1'b0;
        detected_dir = 2'd1;
        chk("brake_state", 32'(state), 32'd4);
        chk("brake_phase", 32'(phase_enable), 32'b000111);
        tick(19);
        chk("brake_last", 32'(state), 32'd4);
        chk("brake_last_ph", 32'(phase_enable), 32'b000111);
        tick(1);
        chk("brake_idle", 32'(state), 32'd0);
        chk("brake_nofault", 32'(fault_code), 32'd0);
        chk("brake_dir", 32'(dir), 32'd0);
        go_run(4);
        detected_dir = 2'd2;
        hall_values = 3'b001;
        tick(1);
        detected_dir = 2'd1;
        chk("rev_state", 32'(state), 32'd5);
        chk("rev_code", 32'(fault_code), 32'd3);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        go_run(4);
        #2 preset_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_phase", 32'(phase_enable), 32'd0);
        chk("async_misc", {29'd0, dir, running}, 32'd0);
        tick(1);
        preset_n = 1'b1;
        tick(2);
        chk("post_rst", 32'(state), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
